// File: rtl/seq_alu_if.sv
// seq_alu_if: start/done handshake, operands and registered result/flags
// for the sequential ALU. The master drives requests, the slave is the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output start, sel, a, b,
    input  busy, done, out, carry, zero, div_by_zero
  );

  modport slave (
    input  start, sel, a, b,
    output busy, done, out, carry, zero, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: clocked 8-function ALU with registered result and flags.
// Add/sub/logic ops finish one cycle after acceptance. Divide and modulus
// use an iterative restoring divider that takes WIDTH cycles; it is only
// built when the macro SEQ_ALU_DIV_EN is defined. Without it, div/mod
// complete in one cycle with a zero result and busy is tied low.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  logic [WIDTH-1:0] out_q, out_n;
  logic             carry_q, carry_n;
  logic             zero_q, zero_n;
  logic             dbz_q, dbz_n;
  logic             done_q, done_n;

  // One extra bit so carry-out and borrow fall out of the top bit.
  logic [WIDTH:0] add_res;
  logic [WIDTH:0] sub_res;
  assign add_res = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_res = {1'b0, bus.a} - {1'b0, bus.b};

`ifdef SEQ_ALU_DIV_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, DIV} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] rem_q, rem_n;
  logic [WIDTH-1:0] quo_q, quo_n;
  logic [WIDTH-1:0] dvsr_q, dvsr_n;
  logic             mod_q, mod_n;
  logic [CW-1:0]    count_q, count_n;

  // The shifted remainder can reach 2*b-1, so it needs one extra bit.
  logic [WIDTH:0] rem_sh;
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};

  assign bus.busy = (state_q == DIV);
`else
  assign bus.busy = 1'b0;
`endif

  assign bus.out         = out_q;
  assign bus.carry       = carry_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.done        = done_q;

  // Next-state and next-result logic: one divider step while dividing,
  // otherwise accept a request and compute single-cycle results.
  always_comb begin
    out_n   = out_q;
    carry_n = carry_q;
    zero_n  = zero_q;
    dbz_n   = dbz_q;
    done_n  = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    state_n = state_q;
    rem_n   = rem_q;
    quo_n   = quo_q;
    dvsr_n  = dvsr_q;
    mod_n   = mod_q;
    count_n = count_q;

    if (state_q == DIV) begin
      count_n = count_q - CW'(1);
      if (rem_sh >= {1'b0, dvsr_q}) begin
        rem_n = rem_sh[WIDTH-1:0] - dvsr_q;
        quo_n = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_n = rem_sh[WIDTH-1:0];
        quo_n = {quo_q[WIDTH-2:0], 1'b0};
      end
      if (count_q == CW'(1)) begin
        out_n   = mod_q ? rem_n : quo_n;
        carry_n = 1'b0;
        dbz_n   = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
      end
    end else if (bus.start) begin
`else
    if (bus.start) begin
`endif
      done_n  = 1'b1;
      carry_n = 1'b0;
      dbz_n   = 1'b0;
      case (bus.sel)
        OP_ADD: begin
          out_n   = add_res[WIDTH-1:0];
          carry_n = add_res[WIDTH];
        end
        OP_SUB: begin
          out_n   = sub_res[WIDTH-1:0];
          carry_n = sub_res[WIDTH];
        end
        OP_OR:  out_n = bus.a | bus.b;
        OP_AND: out_n = bus.a & bus.b;
        OP_XOR: out_n = bus.a ^ bus.b;
        OP_NOT: out_n = ~bus.a;
        default: begin
`ifdef SEQ_ALU_DIV_EN
          if (bus.b == '0) begin
            out_n = bus.sel[0] ? bus.a : '1;
            dbz_n = 1'b1;
          end else begin
            done_n  = 1'b0;
            out_n   = out_q;
            carry_n = carry_q;
            dbz_n   = dbz_q;
            state_n = DIV;
            dvsr_n  = bus.b;
            mod_n   = bus.sel[0];
            rem_n   = '0;
            quo_n   = bus.a;
            count_n = CW'(WIDTH);
          end
`else
          out_n = '0;
`endif
        end
      endcase
    end

    if (done_n) begin
      zero_n = (out_n == '0);
    end
  end

  // Register state and outputs; reset clears everything and aborts a division.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      mod_q   <= 1'b0;
      count_q <= '0;
`endif
    end else begin
      out_q   <= out_n;
      carry_q <= carry_n;
      zero_q  <= zero_n;
      dbz_q   <= dbz_n;
      done_q  <= done_n;
`ifdef SEQ_ALU_DIV_EN
      state_q <= state_n;
      rem_q   <= rem_n;
      quo_q   <= quo_n;
      dvsr_q  <= dvsr_n;
      mod_q   <= mod_n;
      count_q <= count_n;
`endif
    end
  end

endmodule
